// File: rtl/reg_writeback_queue.sv
// Write-back queue: buffers register write requests in arrival order and
// retires one per cycle onto the register file write port. It also flags
// read addresses that still have a queued write, so operand reads can stall.
module reg_writeback_queue #(
    parameter int WORD       = 16,
    parameter int REGISTERS  = 8,
    parameter int READ_PORTS = 2,
    parameter int DEPTH      = 4,
    localparam int AW = $clog2(REGISTERS),
    localparam int BW = WORD / 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    // Handshake: a request transfers on a posedge where wb_valid && wb_ready.
    // wb_ready depends only on registered occupancy, never on drain_en, and
    // the producer holds addr/data/bytes stable while wb_valid waits.
    input  logic                            wb_valid,
    output logic                            wb_ready,
    input  logic [AW-1:0]                   wb_addr,
    input  logic [WORD-1:0]                 wb_data,
    input  logic [BW-1:0]                   wb_bytes,
    input  logic                            drain_en,
    output logic [BW-1:0]                   Reg_wr,
    output logic [AW-1:0]                   wr_addr,
    output logic [WORD-1:0]                 wr_data,
    input  logic [READ_PORTS-1:0][AW-1:0]   rd_addr,
    output logic [READ_PORTS-1:0]           pending,
    output logic [CW-1:0]                   count,
    output logic                            empty
);

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, empty_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    logic [AW-1:0]    addr_q  [DEPTH];
    logic [WORD-1:0]  data_q  [DEPTH];
    logic [BW-1:0]    bytes_q [DEPTH];

    logic push;
    logic pop;

    // Zero-byte requests complete the handshake but are dropped here.
    assign wb_ready = (count_q != CW'(DEPTH));
    assign push     = wb_valid && wb_ready && (wb_bytes != '0);
    assign pop      = drain_en && !empty_q;

    // Next-state for pointers, occupancy and per-entry valid bits.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (push) begin
            tail_d          = tail_q + PW'(1);
            valid_d[tail_q] = 1'b1;
        end
        if (pop) begin
            head_d          = head_q + PW'(1);
            valid_d[head_q] = 1'b0;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
    end

    // Control state register; reset discards every queued write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            empty_q <= empty_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload storage; only meaningful where valid_q is set.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q]  <= wb_addr;
            data_q[tail_q]  <= wb_data;
            bytes_q[tail_q] <= wb_bytes;
        end
    end

    // Register file port driven straight from the head entry while popping.
    always_comb begin
        Reg_wr  = '0;
        wr_addr = '0;
        wr_data = '0;
        if (pop) begin
            Reg_wr  = bytes_q[head_q];
            wr_addr = addr_q[head_q];
            wr_data = data_q[head_q];
        end
    end

    // Hazard flags: any valid entry (including the one retiring now)
    // targeting a read address; a request arriving this cycle is not seen.
    always_comb begin
        pending = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (valid_q[e] && (addr_q[e] == rd_addr[p])) begin
                    pending[p] = 1'b1;
                end
            end
        end
    end

    assign count = count_q;
    assign empty = empty_q;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: reset, single push, fill/drain
// ordering with wrap, hazard flags, zero-byte requests and async reset.
module tb_reg_writeback_queue;

    logic            clk;
    logic            reset;
    logic            wb_valid;
    logic            wb_ready;
    logic [2:0]      wb_addr;
    logic [15:0]     wb_data;
    logic [1:0]      wb_bytes;
    logic            drain_en;
    logic [1:0]      Reg_wr;
    logic [2:0]      wr_addr;
    logic [15:0]     wr_data;
    logic [1:0][2:0] rd_addr;
    logic [1:0]      pending;
    logic [2:0]      count;
    logic            empty;

    int checks;
    int errors;

    logic [2:0]  exp_addr_q[$];
    logic [15:0] exp_q[$];

    reg_writeback_queue #(
        .WORD(16), .REGISTERS(8), .READ_PORTS(2), .DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_bytes(wb_bytes),
        .drain_en(drain_en),
        .Reg_wr(Reg_wr), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .pending(pending),
        .count(count), .empty(empty)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        wb_valid = 1'b0;
        drain_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        rd_addr[0] = 3'd0;
        rd_addr[1] = 3'd0;
        tick();
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty); end
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", wb_ready); end
        checks++; if (Reg_wr !== 2'b00) begin errors++; $display("FAIL reset_reg_wr got %b want 00", Reg_wr); end
        checks++; if (pending !== 2'b00) begin errors++; $display("FAIL reset_pending got %b want 00", pending); end
    endtask

    task automatic test_single_push();
        wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 16'hBEEF; wb_bytes = 2'b11;
        drain_en = 1'b1;
        #1;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %0b want 1", wb_ready); end
        checks++; if (Reg_wr !== 2'b00) begin errors++; $display("FAIL single_no_early got %b want 00", Reg_wr); end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++; if (Reg_wr !== 2'b11) begin errors++; $display("FAIL single_reg_wr got %b want 11", Reg_wr); end
        checks++; if (wr_addr !== 3'd3) begin errors++; $display("FAIL single_addr got %0d want 3", wr_addr); end
        checks++; if (wr_data !== 16'hBEEF) begin errors++; $display("FAIL single_data got %h want beef", wr_data); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
        tick();
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_after got %0b want 1", empty); end
        checks++; if (Reg_wr !== 2'b00) begin errors++; $display("FAIL single_idle got %b want 00", Reg_wr); end
        drain_en = 1'b0;
    endtask

    task automatic test_fill_drain();
        int retired;
        logic pushed;
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            wb_valid = 1'b1; wb_addr = 3'(i); wb_data = 16'h1000 + 16'(i); wb_bytes = 2'b11;
            tick();
            exp_addr_q.push_back(3'(i));
            exp_q.push_back(16'h1000 + 16'(i));
        end
        wb_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", count); end
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %0b want 0", wb_ready); end
        wb_valid = 1'b1; wb_addr = 3'd6; wb_data = 16'h6666;
        tick();
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_fifth_rejected got %0d want 4", count); end
        // drain with R5 offered; it enters once the first pop frees a slot
        wb_addr = 3'd5; wb_data = 16'h1005; drain_en = 1'b1;
        #1;
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready got %0b want 0", wb_ready); end
        retired = 0;
        for (int c = 0; c < 8; c++) begin
            pushed = wb_valid && wb_ready;
            if (Reg_wr != 2'b00) begin
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++; $display("FAIL drain_extra got addr %0d want none", wr_addr);
                end else begin
                    logic [2:0]  ea;
                    logic [15:0] ed;
                    ea = exp_addr_q.pop_front();
                    ed = exp_q.pop_front();
                    if (wr_addr !== ea || wr_data !== ed) begin
                        errors++; $display("FAIL drain_order got %0d/%h want %0d/%h", wr_addr, wr_data, ea, ed);
                    end
                end
                retired++;
            end
            tick();
            if (pushed) begin
                wb_valid = 1'b0;
                exp_addr_q.push_back(3'd5);
                exp_q.push_back(16'h1005);
            end
            #1;
        end
        checks++; if (retired != 5) begin errors++; $display("FAIL drain_retired got %0d want 5", retired); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %0b want 1", empty); end
        drain_en = 1'b0;
        wb_valid = 1'b0;
    endtask

    task automatic test_hazard();
        apply_reset();
        rd_addr[0] = 3'd2;
        rd_addr[1] = 3'd5;
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'h00AA; wb_bytes = 2'b01;
        #1;
        checks++; if (pending !== 2'b00) begin errors++; $display("FAIL haz_push_unseen got %b want 00", pending); end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++; if (pending !== 2'b01) begin errors++; $display("FAIL haz_r2 got %b want 01", pending); end
        drain_en = 1'b1;
        wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 16'h0055; wb_bytes = 2'b11;
        #1;
        checks++; if (pending !== 2'b01) begin errors++; $display("FAIL haz_pop_push got %b want 01", pending); end
        checks++; if (Reg_wr !== 2'b01 || wr_addr !== 3'd2) begin errors++; $display("FAIL haz_retire got %b/%0d want 01/2", Reg_wr, wr_addr); end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++; if (pending !== 2'b10) begin errors++; $display("FAIL haz_r5 got %b want 10", pending); end
        tick();
        #1;
        checks++; if (pending !== 2'b00) begin errors++; $display("FAIL haz_clear got %b want 00", pending); end
        drain_en = 1'b0;
    endtask

    task automatic test_zero_byte();
        apply_reset();
        rd_addr[0] = 3'd7;
        drain_en = 1'b1;
        wb_valid = 1'b1; wb_addr = 3'd7; wb_data = 16'h7777; wb_bytes = 2'b00;
        #1;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL zb_ready got %0b want 1", wb_ready); end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL zb_count got %0d/%0b want 0/1", count, empty); end
        checks++; if (Reg_wr !== 2'b00) begin errors++; $display("FAIL zb_reg_wr got %b want 00", Reg_wr); end
        checks++; if (pending !== 2'b00) begin errors++; $display("FAIL zb_pending got %b want 00", pending); end
        drain_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        rd_addr[0] = 3'd2;
        rd_addr[1] = 3'd3;
        for (int i = 1; i <= 3; i++) begin
            wb_valid = 1'b1; wb_addr = 3'(i); wb_data = 16'h2000 + 16'(i); wb_bytes = 2'b11;
            tick();
        end
        wb_valid = 1'b0;
        drain_en = 1'b1;
        #1;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_count got %0d want 3", count); end
        checks++; if (Reg_wr !== 2'b11 || wr_addr !== 3'd1) begin errors++; $display("FAIL mid_first got %b/%0d want 11/1", Reg_wr, wr_addr); end
        tick();
        #3;
        reset = 1'b1;
        #1;
        checks++; if (Reg_wr !== 2'b00) begin errors++; $display("FAIL mid_reg_wr got %b want 00", Reg_wr); end
        checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL mid_count_rst got %0d/%0b want 0/1", count, empty); end
        checks++; if (pending !== 2'b00 || wb_ready !== 1'b1) begin errors++; $display("FAIL mid_flags got %b/%0b want 00/1", pending, wb_ready); end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (Reg_wr !== 2'b00) begin errors++; $display("FAIL post_rst_write cycle %0d got %b want 00", c, Reg_wr); end
            tick();
        end
        drain_en = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        wb_bytes = '0;
        drain_en = 1'b0;
        rd_addr  = '0;
        test_reset();
        test_single_push();
        test_fill_drain();
        test_hazard();
        test_zero_byte();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
